// File: rtl/szamologep_pkg.sv
// Shared types and constants for the calculator sequencing controller:
// state encoding, opcode values, button indices and the LED state map.
package szamologep_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_OP = 3'd2,
    S_GOT_B  = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int BTN_A    = 3;
  localparam int BTN_OP   = 2;
  localparam int BTN_B    = 1;
  localparam int BTN_EXEC = 0;

  // Entry states light one LED each; RUN and DONE have no status LED.
  function automatic logic [3:0] state_onehot(input state_t s);
    logic [3:0] oh;
    oh = 4'b0000;
    case (s)
      S_IDLE:   oh = 4'b0001;
      S_GOT_A:  oh = 4'b0010;
      S_GOT_OP: oh = 4'b0100;
      S_GOT_B:  oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/szamologep_vezerlo_gomb.sv
// One button input path: 2-flop synchroniser, saturating stable-high counter
// and a single-cycle press pulse when the counter first reaches DEB_CNT.
module gomb_pergesmentesito #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (!sync_q[1]) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Fires only on the step into saturation, so a held button never repeats.
      press <= sync_q[1] && (cnt_q == CNT_LAST);
    end
  end

endmodule

// File: rtl/szamologep_vezerlo.sv
// Calculator sequencing controller: debounced buttons drive the entry order
// opA -> op -> opB -> execute, then a start/done exchange with the ALU.
module szamologep_vezerlo
  import szamologep_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEB_CNT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dip_sw,
  input  logic [3:0]    btn,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [1:0]    op_sel,
  output logic          alu_start,
  output logic          busy,
  output logic          err,
  output logic [DW-1:0] leds,
  output logic [2:0]    state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [DW-1:0] result_q;
  logic [TW-1:0] tmr_q;
  logic [3:0]    ev;
  logic          ev_any;
  logic          ev_multi;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    gomb_pergesmentesito #(.DEB_CNT(DEB_CNT)) u_gomb (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn[g]),
      .press   (ev[g])
    );
  end

  assign ev_any   = |ev;
  assign ev_multi = (ev & (ev - 4'd1)) != 4'd0;

  // ALU handshake: alu_start is a one-cycle pulse issued on entry to RUN;
  // the ALU answers with a one-cycle alu_done carrying alu_result. alu_done
  // is only consumed while in RUN, everywhere else it is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= OP_ADD;
      alu_start <= 1'b0;
      err       <= 1'b0;
      result_q  <= '0;
      tmr_q     <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_RUN: begin
          if (alu_done) begin
            result_q <= alu_result;
            state    <= S_DONE;
          end else if (tmr_q == TMR_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B, S_DONE: begin
          if (ev_multi) begin
            err <= 1'b1;
          end else if (ev[BTN_A] && (state == S_IDLE || state == S_GOT_A ||
                                     state == S_DONE)) begin
            op_a     <= dip_sw;
            err      <= 1'b0;
            result_q <= '0;
            state    <= S_GOT_A;
          end else if (ev_any && state != S_DONE) begin
            case (state)
              S_GOT_A: begin
                if (ev[BTN_OP] && dip_sw[DW-1:2] == '0) begin
                  op_sel <= dip_sw[1:0];
                  state  <= S_GOT_OP;
                end else begin
                  err <= 1'b1;
                end
              end
              S_GOT_OP: begin
                if (ev[BTN_B]) begin
                  op_b  <= dip_sw;
                  state <= S_GOT_B;
                end else begin
                  err <= 1'b1;
                end
              end
              S_GOT_B: begin
                if (!ev[BTN_EXEC]) begin
                  err <= 1'b1;
                end else if (op_sel == OP_DIV && op_b == '0) begin
                  // Division by zero never reaches the ALU.
                  err   <= 1'b1;
                  state <= S_IDLE;
                end else begin
                  alu_start <= 1'b1;
                  tmr_q     <= '0;
                  state     <= S_RUN;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign state_dbg = state;

  always_comb begin
    leds = '0;
    if (state == S_DONE) begin
      leds = result_q;
    end else begin
      leds[DW-1] = err;
      leds[3:0]  = state_onehot(state);
    end
  end

endmodule

// File: doc/szamologep_vezerlo.md
Name: szamologep_vezerlo

Overview:
- Sequencing controller in front of the calculator datapath; sits between board I/O (dip_sw, btn) and the arithmetic unit.
- Synchronises and debounces the four buttons, turns each one into a single-cycle press event, and enforces the entry order opA -> op -> opB -> execute.
- Latches operands, starts the multi-cycle ALU with a start/done handshake, captures the result and drives leds with the result or status/error.

Parameters:
- DW, 8, operand/result width.
- DEB_CNT, 4, consecutive stable-high synchronised cycles before a press is accepted.
- TIMEOUT, 64, max cycles in RUN waiting for alu_done before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dip_sw  in  DW  operand/opcode entry switches.
- btn  in  4  raw buttons: [3]=load A, [2]=load op, [1]=load B, [0]=execute.
- alu_done  in  1  single-cycle pulse from the ALU when the result is valid.
- alu_result  in  DW  ALU result, sampled when alu_done=1.
- op_a  out  DW  latched operand A.
- op_b  out  DW  latched operand B.
- op_sel  out  2  latched opcode: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  single-cycle start pulse to the ALU.
- busy  out  1  high in RUN.
- err  out  1  sticky error flag.
- leds  out  DW  result when in DONE, otherwise {err, 3'b0, state one-hot[3:0]}.

Behaviour:
- Reset (reset=0, async): all registers 0, state IDLE, debounce counters 0, sync flops 0, leds=8'h01.
- Input path:
  - btn goes through a 2-flop synchroniser.
  - Per-button counter counts consecutive synchronised-high cycles and saturates at DEB_CNT.
  - Press event is a 1-cycle pulse on the cycle the counter reaches DEB_CNT.
  - Counter clears when the synchronised input goes low; no repeat while held.
  - Latency from raw rise to event pulse: 2 + DEB_CNT cycles (6 at default).
- Simultaneous events (more than one press pulse in the same cycle): all ignored, err<=1, state unchanged.
- State machine (leds one-hot index in brackets):
  - IDLE [0]: waiting for A.
  - GOT_A [1]: A loaded.
  - GOT_OP [2]: op loaded.
  - GOT_B [3]: B loaded.
  - RUN: waiting for the ALU.
  - DONE: result shown.
- Transitions:
  - IDLE + A press: op_a<=dip_sw, err<=0, go to GOT_A.
  - GOT_A + op press:
    - If dip_sw[DW-1:2]==0: op_sel<=dip_sw[1:0], go to GOT_OP.
    - Otherwise err<=1 and stay in GOT_A.
  - GOT_OP + B press: op_b<=dip_sw, go to GOT_B.
  - GOT_B + exec press:
    - If op_sel==3 and op_b==0: err<=1, go to IDLE, no start.
    - Otherwise alu_start=1 for exactly one cycle, go to RUN.
  - RUN: on alu_done, capture alu_result into the result register and go to DONE. Every press event is ignored and no error is raised.
  - RUN timeout: the cycle counter reaches TIMEOUT without alu_done -> err<=1, go to IDLE.
  - DONE + A press: same as IDLE + A press (a new calculation starts; the result is cleared).
  - DONE + any other press: ignored.
- Out-of-order press in IDLE/GOT_*: err<=1, state and registers unchanged.
- A press in the current state re-loads that field only where the state accepts it:
  - A in GOT_A: re-latch op_a, stay in GOT_A.
  - Every other repeat is out-of-order.
- err is sticky and is cleared only by an accepted A press or by reset.
- alu_done outside RUN is ignored.
- Reset mid-RUN: the controller returns to IDLE immediately; any later alu_done is ignored.
- busy=1 exactly while in RUN. alu_start is never asserted outside the GOT_B->RUN transition.

Decomposition:
- Package szamologep_pkg:
  - state encoding.
  - opcode constants OP_ADD/SUB/MUL/DIV.
  - button index constants BTN_A=3, BTN_OP=2, BTN_B=1, BTN_EXEC=0.
- One sub-module, gomb_pergesmentesito: synchroniser + debounce + one-shot for one button, parameterised by DEB_CNT, instantiated 4 times.

Test Plan:
- Reset held 100 ns, then released -> leds=8'h01, all outputs 0, alu_start never pulses.
- Full sequence:
  - Stimulus: dip_sw=15 + btn=8; dip_sw=1 + btn=4; dip_sw=3 + btn=2; btn=1. Each button held 150 ns; ALU model returns done after 5 cycles with 12.
  - Response: exactly one alu_start; op_a=15, op_sel=1, op_b=3; busy high 5 cycles; leds=12.
- Button held continuously for 20 cycles -> exactly one press event. Press pulse of DEB_CNT-1 cycles -> no event.
- Execute pressed in IDLE -> err=1, leds=8'h81. A subsequent A press with dip_sw=7 -> err=0, op_a=7, leds=8'h02.
- Divide by zero:
  - Stimulus: A=9, op dip_sw=3, B=0, execute.
  - Response: no alu_start, err=1, state IDLE.
- Opcode error and timeout:
  - Op press with dip_sw=8'h04 -> err=1, remain in GOT_A.
  - Separately, ALU never answers -> err=1 and IDLE after 64 cycles in RUN.
